// File: rtl/prog_loader_if.sv
// Host-side byte stream into the program loader: valid/ready handshake.
interface prog_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams host words into program RAM at consecutive
// addresses while holding the CPU sequencer stopped.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    prog_loader_if.slave      host,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wr,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] remaining;
    logic              in_ready_q;

    assign host.in_ready = in_ready_q;

    // Outputs are registered alongside the state, so each one is set to the
    // value belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            checksum   <= '0;
            in_ready_q <= 1'b0;
            ram_wr     <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        checksum <= '0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        if (len != '0) begin
                            ram_addr   <= base_addr;
                            remaining  <= len;
                            in_ready_q <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    // Abort wins over a simultaneous handshake: that word is dropped.
                    if (abort) begin
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                        state      <= IDLE;
                    end else if (host.in_valid) begin
                        ram_din    <= host.in_data;
                        checksum   <= checksum + host.in_data;
                        in_ready_q <= 1'b0;
                        ram_wr     <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    ram_wr    <= 1'b0;
                    ram_addr  <= ram_addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                    if (abort) begin
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                    end else if (remaining == ADDR_W'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state      <= LOAD;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected RAM writes
// plus per-scenario checks on done timing, hold window and checksum.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] len;
    logic       abort;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_wr;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    prog_loader_if #(.DATA_W(8)) host_if ();

    prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .abort    (abort),
        .host     (host_if),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_wr   (ram_wr),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycleCnt    = 0;
    int          writeCount  = 0;
    int          doneCount   = 0;
    int          holdCount   = 0;
    int          doneCycle   = 0;
    int          startCycle  = 0;
    logic [15:0] sb[$];
    logic [7:0]  words[8];
    logic [7:0]  expSum;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [15:0] exp;
        if (ram_wr) begin
            writeCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_wr", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                checkOutput("wr_addr", 32'(ram_addr), 32'(exp[15:8]));
                checkOutput("wr_data", 32'(ram_din), 32'(exp[7:0]));
            end
        end
        if (done) begin
            doneCount++;
            doneCycle = cycleCnt;
        end
        if (cpu_hold) holdCount++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic [7:0] base, input logic [7:0] n);
        start      = 1'b1;
        base_addr  = base;
        len        = n;
        startCycle = cycleCnt;
        tick();
        start     = 1'b0;
        base_addr = 8'h00;
        len       = 8'h00;
    endtask

    task automatic pushExpected(input logic [7:0] base, input int n);
        logic [7:0] a;
        expSum = 8'h00;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            sb.push_back({a, words[i]});
            expSum = expSum + words[i];
        end
    endtask

    task automatic feedWords(input int n, input int stall);
        int guard;
        for (int i = 0; i < n; i++) begin
            host_if.in_valid = 1'b1;
            host_if.in_data  = words[i];
            guard = 0;
            while (!host_if.in_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20) checkOutput("ready_timeout", 32'd0, 32'd1);
            tick();
            host_if.in_valid = 1'b0;
            host_if.in_data  = 8'hXX;
            if (stall > 0 && i < n - 1) begin
                tick();
                for (int s = 0; s < stall; s++) begin
                    checkOutput("stall_ready", 32'(host_if.in_ready), 32'd1);
                    tick();
                end
            end
        end
    endtask

    task automatic waitIdle;
        int guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] n,
                                 input int stall, input string tag);
        int w0, d0, h0;
        pushExpected(base, int'(n));
        w0 = writeCount;
        d0 = doneCount;
        h0 = holdCount;
        pulseStart(base, n);
        feedWords(int'(n), stall);
        waitIdle();
        checkOutput({tag, "_writes"}, 32'(writeCount - w0), 32'(n));
        checkOutput({tag, "_done_cnt"}, 32'(doneCount - d0), 32'd1);
        checkOutput({tag, "_checksum"}, 32'(checksum), 32'(expSum));
        if (stall == 0) begin
            checkOutput({tag, "_done_lat"}, 32'(doneCycle - startCycle), 32'(2 * n + 1));
            checkOutput({tag, "_hold_cyc"}, 32'(holdCount - h0), 32'(2 * n + 1));
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_addr"}, 32'(ram_addr), 32'd0);
        checkOutput({tag, "_din"}, 32'(ram_din), 32'd0);
        checkOutput({tag, "_sum"}, 32'(checksum), 32'd0);
        checkOutput({tag, "_ctrl"},
                    32'({host_if.in_ready, ram_wr, busy, cpu_hold, done}), 32'd0);
    endtask

    task automatic setBasicWords;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    endtask

    initial begin
        int w0, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = 8'h00; len = 8'h00;
        host_if.in_valid = 1'b0; host_if.in_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        checkResetValues("reset");
        tick();

        // Basic load
        setBasicWords();
        applyStimulus(8'h00, 8'd4, 0, "basic");
        checkOutput("basic_hold_after", 32'(cpu_hold), 32'd0);

        // Host stalls
        applyStimulus(8'h00, 8'd4, 3, "stall");

        // Wrap, then zero length
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        applyStimulus(8'hFE, 8'd3, 0, "wrap");
        w0 = writeCount;
        pulseStart(8'h40, 8'd0);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_sum", 32'(checksum), 32'd0);
        tick();
        checkOutput("zero_done_end", 32'({done, busy}), 32'd0);
        checkOutput("zero_writes", 32'(writeCount - w0), 32'd0);

        // Abort in WRITE of second word
        words[0] = 8'h3C; words[1] = 8'h81;
        pushExpected(8'h10, 2);
        w0 = writeCount; d0 = doneCount;
        pulseStart(8'h10, 8'd4);
        feedWords(2, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortw_idle", 32'({busy, cpu_hold, host_if.in_ready}), 32'd0);
        tick(); tick(); tick();
        checkOutput("abortw_writes", 32'(writeCount - w0), 32'd2);
        checkOutput("abortw_done", 32'(doneCount - d0), 32'd0);
        checkOutput("abortw_sum", 32'(checksum), 32'(8'h3C + 8'h81));

        // Abort in LOAD before the first word
        w0 = writeCount; d0 = doneCount;
        pulseStart(8'h20, 8'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortl_idle", 32'({busy, cpu_hold, host_if.in_ready}), 32'd0);
        tick(); tick();
        checkOutput("abortl_writes", 32'(writeCount - w0), 32'd0);
        checkOutput("abortl_done", 32'(doneCount - d0), 32'd0);
        checkOutput("abortl_sum", 32'(checksum), 32'd0);

        // Reset mid-load after one word
        setBasicWords();
        pushExpected(8'h00, 1);
        w0 = writeCount;
        pulseStart(8'h00, 8'd4);
        feedWords(1, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetValues("midrst");
        host_if.in_valid = 1'b1;
        host_if.in_data  = 8'h77;
        repeat (6) tick();
        host_if.in_valid = 1'b0;
        checkOutput("midrst_writes", 32'(writeCount - w0), 32'd1);
        applyStimulus(8'h00, 8'd4, 0, "postrst");

        // Start while busy is ignored
        words[0] = 8'h5A; words[1] = 8'h01; words[2] = 8'h02;
        pushExpected(8'h30, 3);
        w0 = writeCount; d0 = doneCount;
        pulseStart(8'h30, 8'd3);
        start = 1'b1; base_addr = 8'h80; len = 8'd7;
        tick();
        start = 1'b0; base_addr = 8'h00; len = 8'h00;
        feedWords(3, 0);
        waitIdle();
        checkOutput("busystart_writes", 32'(writeCount - w0), 32'd3);
        checkOutput("busystart_done", 32'(doneCount - d0), 32'd1);
        checkOutput("busystart_sum", 32'(checksum), 32'h5D);

        tick(); tick();
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
